// File: rtl/core_acc_multi.sv
// Multi-lane signed psum accumulator: sums LANES streams over groups of (cfg_acc_num+1) beats,
// with optional saturation, early flush and a registered valid/ready output slot.
module core_acc_multi #(
  parameter int LANES     = 4,
  parameter int IDATA_BIT = 32,
  parameter int ODATA_BIT = 32,
  parameter int CDATA_BIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CDATA_BIT-1:0]         cfg_acc_num,
  input  logic                         cfg_sat_en,
  input  logic                         acc_flush,
  input  logic [LANES*IDATA_BIT-1:0]   idata,
  input  logic                         idata_valid,
  output logic                         idata_ready,
  output logic [LANES*ODATA_BIT-1:0]   odata,
  output logic                         odata_valid,
  input  logic                         odata_ready,
  output logic                         odata_sat
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [CDATA_BIT-1:0]       cnt_q, cnt_d, num_q, num_d;
  logic [LANES*ODATA_BIT-1:0] acc_q, acc_d, odata_q, odata_d;
  logic                       sat_flag_q, sat_flag_d;
  logic                       flush_pend_q, flush_pend_d;
  logic                       odata_valid_q, odata_valid_d;
  logic                       odata_sat_q, odata_sat_d;

  logic [LANES*ODATA_BIT-1:0] sum_red;
  logic [LANES-1:0]           lane_sat;
  logic flush_act, last_beat, closing, blocked, accept, close_fire;

  // Readiness is derived from idata_valid (not accept) to keep the ready path loop-free.
  always_comb begin
    flush_act = (state_q == S_ACCUM) && (acc_flush || flush_pend_q);
    if (state_q == S_IDLE) last_beat = idata_valid && ((cfg_acc_num == '0) || acc_flush);
    else                   last_beat = idata_valid && (cnt_q == num_q);
    closing     = flush_act || last_beat;
    blocked     = odata_valid_q && !odata_ready;
    idata_ready = !(closing && blocked);
    accept      = idata_valid && idata_ready;
    close_fire  = closing && !blocked;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [ODATA_BIT:0] in_ext, acc_ext, sum;
    logic                      ovf;
    logic [ODATA_BIT-1:0]      red;

    assign in_ext  = accept ? {{(ODATA_BIT+1-IDATA_BIT){idata[l*IDATA_BIT+IDATA_BIT-1]}},
                               idata[l*IDATA_BIT +: IDATA_BIT]} : '0;
    assign acc_ext = {acc_q[l*ODATA_BIT+ODATA_BIT-1], acc_q[l*ODATA_BIT +: ODATA_BIT]};
    assign sum     = in_ext + acc_ext;
    assign ovf     = sum[ODATA_BIT] ^ sum[ODATA_BIT-1];

    always_comb begin
      if (cfg_sat_en && ovf)
        red = sum[ODATA_BIT] ? {1'b1, {(ODATA_BIT-1){1'b0}}} : {1'b0, {(ODATA_BIT-1){1'b1}}};
      else
        red = sum[ODATA_BIT-1:0];
    end

    assign sum_red[l*ODATA_BIT +: ODATA_BIT] = red;
    assign lane_sat[l] = cfg_sat_en && ovf;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    num_d         = num_q;
    acc_d         = acc_q;
    sat_flag_d    = sat_flag_q;
    flush_pend_d  = flush_pend_q;
    odata_d       = odata_q;
    odata_valid_d = odata_valid_q;
    odata_sat_d   = odata_sat_q;

    if (odata_valid_q && odata_ready) odata_valid_d = 1'b0;

    if (close_fire) begin
      odata_d       = sum_red;
      odata_valid_d = 1'b1;
      odata_sat_d   = sat_flag_q || (|lane_sat);
      acc_d         = '0;
      cnt_d         = '0;
      sat_flag_d    = 1'b0;
      flush_pend_d  = 1'b0;
      state_d       = S_IDLE;
    end else begin
      if (flush_act) flush_pend_d = 1'b1;
      if (accept) begin
        acc_d      = sum_red;
        sat_flag_d = sat_flag_q || (|lane_sat);
        cnt_d      = cnt_q + CDATA_BIT'(1);
        state_d    = S_ACCUM;
        if (state_q == S_IDLE) num_d = cfg_acc_num;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      num_q         <= '0;
      acc_q         <= '0;
      sat_flag_q    <= 1'b0;
      flush_pend_q  <= 1'b0;
      odata_q       <= '0;
      odata_valid_q <= 1'b0;
      odata_sat_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      num_q         <= num_d;
      acc_q         <= acc_d;
      sat_flag_q    <= sat_flag_d;
      flush_pend_q  <= flush_pend_d;
      odata_q       <= odata_d;
      odata_valid_q <= odata_valid_d;
      odata_sat_q   <= odata_sat_d;
    end
  end

  assign odata       = odata_q;
  assign odata_valid = odata_valid_q;
  assign odata_sat   = odata_sat_q;

endmodule

// File: tb/tb_core_acc_multi.sv
// Bench for core_acc_multi (4 lanes, 8-bit in/out): directed literal cases plus randomized
// traffic compared every cycle against an integer group-sum model.
module tb_core_acc_multi;
  localparam int LANES = 4;
  localparam int IW    = 8;
  localparam int OW    = 8;
  localparam int CW    = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CW-1:0]         cfg_acc_num;
  logic                  cfg_sat_en;
  logic                  acc_flush;
  logic [LANES*IW-1:0]   idata;
  logic                  idata_valid;
  logic                  idata_ready;
  logic [LANES*OW-1:0]   odata;
  logic                  odata_valid;
  logic                  odata_ready;
  logic                  odata_sat;

  core_acc_multi #(.LANES(LANES), .IDATA_BIT(IW), .ODATA_BIT(OW), .CDATA_BIT(CW)) dut (
    .clk(clk), .rst(rst), .cfg_acc_num(cfg_acc_num), .cfg_sat_en(cfg_sat_en),
    .acc_flush(acc_flush), .idata(idata), .idata_valid(idata_valid), .idata_ready(idata_ready),
    .odata(odata), .odata_valid(odata_valid), .odata_ready(odata_ready), .odata_sat(odata_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: group progress as a beat count against a group length, sums as plain ints.
  int  m_acc[LANES];
  int  m_od[LANES];
  int  nxt[LANES];
  int  m_beats, m_len;
  bit  m_sat, m_pend, m_ov, m_osat;

  function automatic logic [31:0] pack_od();
    logic [31:0] r;
    for (int l = 0; l < LANES; l++) r[8*l +: 8] = 8'(m_od[l]);
    return r;
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < LANES; l++) begin m_acc[l] = 0; m_od[l] = 0; end
    m_beats = 0; m_len = 1; m_sat = 0; m_pend = 0; m_ov = 0; m_osat = 0;
  endfunction

  initial model_reset();

  bit  flush_here, closing_m, blocked_m, exp_ready, accept_m, fire_m, stepsat;
  int  len_now, s;
  byte b;

  always @(negedge clk) begin
    if (rst) model_reset();
    flush_here = acc_flush || m_pend;
    len_now    = (m_beats == 0) ? int'(cfg_acc_num) + 1 : m_len;
    closing_m  = (flush_here && (m_beats > 0 || idata_valid)) ||
                 (idata_valid && (m_beats + 1 == len_now));
    blocked_m  = m_ov && !odata_ready;
    exp_ready  = !(closing_m && blocked_m);

    chk("idata_ready", idata_ready, exp_ready);
    chk("odata_valid", odata_valid, m_ov);
    if (m_ov) begin
      chk("odata", odata, pack_od());
      chk("odata_sat", odata_sat, m_osat);
    end

    if (!rst) begin
      accept_m = idata_valid && exp_ready;
      fire_m   = closing_m && !blocked_m;
      stepsat  = 0;
      for (int l = 0; l < LANES; l++) begin
        b = byte'(idata[8*l +: 8]);
        s = m_acc[l] + (accept_m ? int'(b) : 0);
        if (s > 127 || s < -128) begin
          if (cfg_sat_en) begin
            stepsat = 1;
            s = (s > 127) ? 127 : -128;
          end else begin
            s = s & 255;
            if (s > 127) s = s - 256;
          end
        end
        nxt[l] = s;
      end
      if (fire_m) begin
        for (int l = 0; l < LANES; l++) begin m_od[l] = nxt[l]; m_acc[l] = 0; end
        m_osat = m_sat || stepsat;
        m_ov = 1; m_beats = 0; m_sat = 0; m_pend = 0;
      end else begin
        if (m_ov && odata_ready) m_ov = 0;
        if (flush_here && m_beats > 0) m_pend = 1;
        if (accept_m) begin
          if (m_beats == 0) m_len = len_now;
          for (int l = 0; l < LANES; l++) m_acc[l] = nxt[l];
          m_sat = m_sat || stepsat;
          m_beats++;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, output int waited);
    bit ok;
    idata = d; idata_valid = 1'b1; waited = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); ok = idata_ready;
      @(posedge clk); #1;
      if (ok) begin idata_valid = 1'b0; return; end
      waited++;
    end
    n_checks++; n_fail++;
    $display("FAIL send_timeout: beat %0h not accepted within 40 cycles", d);
    idata_valid = 1'b0;
  endtask

  int w;

  initial begin
    rst = 1'b1; cfg_acc_num = '0; cfg_sat_en = 1'b0; acc_flush = 1'b0;
    idata = '0; idata_valid = 1'b0; odata_ready = 1'b1;
    #2;
    chk("rst_ready", idata_ready, 1);
    chk("rst_ovalid", odata_valid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_osat", odata_sat, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(1);

    // T1: four beats, lane k = k+1
    cfg_acc_num = 3;
    for (int i = 0; i < 3; i++) send(32'h04030201, w);
    chk("t1_no_early_valid", odata_valid, 0);
    send(32'h04030201, w);
    chk("t1_valid", odata_valid, 1);
    chk("t1_odata", odata, 32'h100C0804);
    chk("t1_model", pack_od(), 32'h100C0804);
    chk("t1_sat", odata_sat, 0);
    idle(1);
    chk("t1_valid_drop", odata_valid, 0);

    // T2: single-beat groups back to back
    cfg_acc_num = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'h07070707, w);
      chk("t2_wait", w, 0);
      chk("t2_valid", odata_valid, 1);
      chk("t2_odata", odata, 32'h07070707);
    end
    idle(1);

    // T3: saturate vs wrap
    cfg_acc_num = 2; cfg_sat_en = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h64646464, w);
    chk("t3_sat_odata", odata, 32'h7F7F7F7F);
    chk("t3_sat_flag", odata_sat, 1);
    idle(1);
    cfg_sat_en = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h64646464, w);
    chk("t3_wrap_odata", odata, 32'h2C2C2C2C);
    chk("t3_wrap_flag", odata_sat, 0);
    idle(1);

    // T4: backpressure holds first group, stalls only the second group's final beat
    cfg_acc_num = 1; odata_ready = 1'b0;
    send(32'h01010101, w);
    send(32'h02020202, w);
    chk("t4_g1_valid", odata_valid, 1);
    chk("t4_g1_odata", odata, 32'h03030303);
    send(32'h0A0A0A0A, w);
    chk("t4_nonfinal_wait", w, 0);
    idata = 32'h14141414; idata_valid = 1'b1;
    @(negedge clk);
    chk("t4_ready_low", idata_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_ready_low2", idata_ready, 0);
    chk("t4_hold_odata", odata, 32'h03030303);
    @(posedge clk); #1; odata_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_release", idata_ready, 1);
    @(posedge clk); #1; idata_valid = 1'b0;
    chk("t4_g2_valid", odata_valid, 1);
    chk("t4_g2_odata", odata, 32'h1E1E1E1E);
    idle(1);
    chk("t4_drain", odata_valid, 0);

    // T5: flush a partial group, next group starts clean
    cfg_acc_num = 9;
    for (int i = 0; i < 3; i++) send(32'hFEFEFEFE, w);
    acc_flush = 1'b1;
    @(posedge clk); #1; acc_flush = 1'b0;
    chk("t5_flush_valid", odata_valid, 1);
    chk("t5_flush_odata", odata, 32'hFAFAFAFA);
    cfg_acc_num = 3;
    for (int i = 0; i < 4; i++) send(32'h01010101, w);
    chk("t5_next_odata", odata, 32'h04040404);
    idle(1);

    // T6: reset mid-group
    for (int i = 0; i < 2; i++) send(32'h01010101, w);
    rst = 1'b1; #1;
    chk("t6_rst_ovalid", odata_valid, 0);
    chk("t6_rst_odata", odata, 0);
    chk("t6_rst_ready", idata_ready, 1);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h01010101, w);
    chk("t6_fresh_odata", odata, 32'h04040404);
    idle(1);

    // Randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      cfg_sat_en = 1'($urandom_range(0, 1));
      for (int c = 0; c < 200; c++) begin
        idata_valid = ($urandom % 10) < 7;
        if (blk % 2 == 0) idata = $urandom;
        else for (int l = 0; l < LANES; l++) idata[8*l +: 8] = 8'($urandom_range(0, 15) - 8);
        acc_flush   = ($urandom % 20) == 0;
        odata_ready = ($urandom % 10) < 6;
        if ($urandom % 8 == 0) cfg_acc_num = CW'($urandom_range(0, 4));
        rst = (blk == 7 && c == 100);
        @(posedge clk); #1;
      end
    end
    rst = 1'b0; idata_valid = 1'b0; acc_flush = 1'b0; odata_ready = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
